// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle; master is the control unit.
interface mc_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             memread;
    logic             memwrite;
    logic             iord;
    logic             irwrite;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [2:0]       alucont;
    logic [1:0]       pcsrc;
    logic             pcen;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct, zero, mem_ready,
        output memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucont, pcsrc, pcen, illegal, instret
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucont, pcsrc, pcen, illegal, instret
    );
endinterface

// File: rtl/mc_aludec.sv
// R-type funct decoder: ALU operation plus a flag for recognised functs.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucont,
    output logic       valid
);

    // Map each supported funct to its ALU code; unknown functs fall back to add.
    always_comb begin
        alucont = ALU_ADD;
        valid   = 1'b1;
        case (funct)
            FN_ADD:  alucont = ALU_ADD;
            FN_SUB:  alucont = ALU_SUB;
            FN_AND:  alucont = ALU_AND;
            FN_OR:   alucont = ALU_OR;
            FN_SLT:  alucont = ALU_SLT;
            default: valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: state sequencing, datapath controls,
// memory handshake stalls and a retired-instruction counter.
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WAIT_MEM   = 1,
    parameter int ENABLE_BNE = 1
) (
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             rdy;
    logic             retire;
    logic             is_beq;
    logic             is_bne;
    logic             fn_valid;
    logic [2:0]       fn_alucont;

    assign rdy    = bus.mem_ready | (WAIT_MEM == 0);
    assign is_beq = (bus.op == OP_BEQ);
    assign is_bne = (ENABLE_BNE != 0) && (bus.op == OP_BNE);

    mc_aludec u_aludec (
        .funct   (bus.funct),
        .alucont (fn_alucont),
        .valid   (fn_valid)
    );

    // Next-state selection and detection of the edge that retires an instruction.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_FETCH:   if (rdy) state_next = S_DECODE;
            S_DECODE: begin
                if (bus.op == OP_LW || bus.op == OP_SW) state_next = S_MEMADR;
                else if (bus.op == OP_RTYPE)            state_next = S_EXECUTE;
                else if (is_beq || is_bne)              state_next = S_BRANCH;
                else if (bus.op == OP_ADDI)             state_next = S_ADDIEX;
                else if (bus.op == OP_J)                state_next = S_JUMP;
                else                                    state_next = S_FETCH;
            end
            S_MEMADR:  state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (rdy) state_next = S_MEMWB;
            S_MEMWR: begin
                if (rdy) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXECUTE: state_next = fn_valid ? S_ALUWB : S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // State register and retired-instruction counter; reset wins over any retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            count <= '0;
        end else begin
            state <= state_next;
            if (retire) count <= count + CNT_W'(1);
        end
    end

    // Moore-style control decode; everything is held at zero while in reset.
    always_comb begin
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.iord     = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = SRCB_B;
        bus.alucont  = ALU_ADD;
        bus.pcsrc    = PC_ALU;
        bus.pcen     = 1'b0;
        bus.illegal  = 1'b0;
        bus.instret  = count;
        case (state)
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = SRCB_FOUR;
                bus.irwrite = rdy;
                bus.pcen    = rdy;
            end
            S_DECODE: begin
                bus.alusrcb = SRCB_IMMSH;
                bus.illegal = !(bus.op == OP_LW || bus.op == OP_SW || bus.op == OP_RTYPE ||
                                is_beq || is_bne || bus.op == OP_ADDI || bus.op == OP_J);
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.iord    = 1'b1;
                bus.memread = 1'b1;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                bus.alucont = fn_alucont;
                bus.illegal = !fn_valid;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                bus.alucont = ALU_SUB;
                bus.pcsrc   = PC_ALUOUT;
                bus.pcen    = (is_beq & bus.zero) | (is_bne & ~bus.zero);
            end
            S_ADDIWB:  bus.regwrite = 1'b1;
            S_JUMP: begin
                bus.pcsrc = PC_JUMP;
                bus.pcen  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            bus.memread  = 1'b0;
            bus.memwrite = 1'b0;
            bus.iord     = 1'b0;
            bus.irwrite  = 1'b0;
            bus.regdst   = 1'b0;
            bus.memtoreg = 1'b0;
            bus.regwrite = 1'b0;
            bus.alusrca  = 1'b0;
            bus.alusrcb  = 2'b00;
            bus.alucont  = 3'b000;
            bus.pcsrc    = 2'b00;
            bus.pcen     = 1'b0;
            bus.illegal  = 1'b0;
            bus.instret  = '0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Randomised bench for mc_controller: a per-instruction reference model
// expands each instruction into its expected per-cycle control vectors.
module tb_mc_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucont;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic ready;
        ctl_t exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    int          check_count = 0;
    int          pass_count = 0;
    int          sel = 0;
    bit          cur_wait = 1'b1;
    bit          cur_bne = 1'b1;
    int          cur_w = 32;
    logic [31:0] model_cnt = 32'd0;
    step_t       q[$];

    logic [5:0] op_tab [0:8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                 6'b001000, 6'b000010, 6'b001101, 6'b111111};
    logic [5:0] fn_tab [0:4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    mc_if #(.CNT_W(32)) bus_a ();
    mc_if #(.CNT_W(4))  bus_b ();

    assign bus_a.op = op;
    assign bus_a.funct = funct;
    assign bus_a.zero = zero;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.op = op;
    assign bus_b.funct = funct;
    assign bus_b.zero = zero;
    assign bus_b.mem_ready = mem_ready;

    mc_controller #(.CNT_W(32), .WAIT_MEM(1), .ENABLE_BNE(1)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    mc_controller #(.CNT_W(4), .WAIT_MEM(0), .ENABLE_BNE(0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    ctl_t obs_a;
    ctl_t obs_b;
    assign obs_a = {bus_a.memread, bus_a.memwrite, bus_a.iord, bus_a.irwrite, bus_a.regdst,
                    bus_a.memtoreg, bus_a.regwrite, bus_a.alusrca, bus_a.alusrcb,
                    bus_a.alucont, bus_a.pcsrc, bus_a.pcen, bus_a.illegal};
    assign obs_b = {bus_b.memread, bus_b.memwrite, bus_b.iord, bus_b.irwrite, bus_b.regdst,
                    bus_b.memtoreg, bus_b.regwrite, bus_b.alusrca, bus_b.alusrcb,
                    bus_b.alucont, bus_b.pcsrc, bus_b.pcen, bus_b.illegal};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic ctl_t cur_obs();
        return (sel == 1) ? obs_b : obs_a;
    endfunction

    function automatic logic [31:0] cur_instret();
        return (sel == 1) ? {28'd0, bus_b.instret} : bus_a.instret;
    endfunction

    function automatic logic [31:0] cnt_mask();
        return (cur_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cur_w) - 32'd1);
    endfunction

    function automatic ctl_t base();
        ctl_t c = '0;
        c.alucont = 3'b010;
        return c;
    endfunction

    function automatic bit fn_decode(input logic [5:0] f, output logic [2:0] ac);
        ac = 3'b010;
        case (f)
            6'b100000: begin ac = 3'b010; return 1'b1; end
            6'b100010: begin ac = 3'b110; return 1'b1; end
            6'b100100: begin ac = 3'b000; return 1'b1; end
            6'b100101: begin ac = 3'b001; return 1'b1; end
            6'b101010: begin ac = 3'b111; return 1'b1; end
            default:   return 1'b0;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        else
            pass_count++;
    endtask

    task automatic push_any(input ctl_t c);
        step_t s;
        s.ready = 1'($urandom_range(0, 1));
        s.exp = c;
        q.push_back(s);
    endtask

    task automatic push_mem(input int nstall, input ctl_t wait_c, input ctl_t done_c);
        step_t s;
        if (cur_wait) begin
            for (int i = 0; i < nstall; i++) begin
                s.ready = 1'b0;
                s.exp = wait_c;
                q.push_back(s);
            end
            s.ready = 1'b1;
        end else begin
            s.ready = 1'b0;
        end
        s.exp = done_c;
        q.push_back(s);
    endtask

    // Reference model: expand one instruction into expected per-cycle controls.
    task automatic build_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input int fstall, input int mstall, output bit retire);
        ctl_t c;
        ctl_t w;
        logic [2:0] ac;
        bit fv;
        bit is_lw   = (o == 6'b100011);
        bit is_sw   = (o == 6'b101011);
        bit is_r    = (o == 6'b000000);
        bit is_beq  = (o == 6'b000100);
        bit is_bne  = (o == 6'b000101) && cur_bne;
        bit is_addi = (o == 6'b001000);
        bit is_j    = (o == 6'b000010);
        retire = 1'b0;
        w = base(); w.memread = 1'b1; w.alusrcb = 2'b01;
        c = w; c.irwrite = 1'b1; c.pcen = 1'b1;
        push_mem(fstall, w, c);
        c = base(); c.alusrcb = 2'b11;
        c.illegal = !(is_lw || is_sw || is_r || is_beq || is_bne || is_addi || is_j);
        push_any(c);
        if (is_lw || is_sw) begin
            c = base(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
            push_any(c);
            c = base(); c.iord = 1'b1; c.memread = is_lw; c.memwrite = is_sw;
            push_mem(mstall, c, c);
            if (is_lw) begin
                c = base(); c.memtoreg = 1'b1; c.regwrite = 1'b1;
                push_any(c);
            end
            retire = 1'b1;
        end else if (is_r) begin
            fv = fn_decode(f, ac);
            c = base(); c.alusrca = 1'b1; c.alucont = ac; c.illegal = !fv;
            push_any(c);
            if (fv) begin
                c = base(); c.regdst = 1'b1; c.regwrite = 1'b1;
                push_any(c);
                retire = 1'b1;
            end
        end else if (is_beq || is_bne) begin
            c = base(); c.alusrca = 1'b1; c.alucont = 3'b110; c.pcsrc = 2'b01;
            c.pcen = is_beq ? z : !z;
            push_any(c);
            retire = 1'b1;
        end else if (is_addi) begin
            c = base(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
            push_any(c);
            c = base(); c.regwrite = 1'b1;
            push_any(c);
            retire = 1'b1;
        end else if (is_j) begin
            c = base(); c.pcsrc = 2'b10; c.pcen = 1'b1;
            push_any(c);
            retire = 1'b1;
        end
    endtask

    // Run one instruction (or its first 'limit' cycles) and check every cycle.
    task automatic apply_stimulus(input string tag, input logic [5:0] o, input logic [5:0] f,
                                  input logic z, input int fstall, input int mstall,
                                  input int limit);
        bit retire;
        int n = 0;
        step_t s;
        op = o;
        funct = f;
        zero = z;
        q.delete();
        build_instr(o, f, z, fstall, mstall, retire);
        while (q.size() > 0 && (limit == 0 || n < limit)) begin
            s = q.pop_front();
            mem_ready = s.ready;
            @(negedge clk);
            check_output($sformatf("%s op=%b fn=%b c%0d", tag, o, f, n), 32'(cur_obs()),
                         32'(s.exp));
            @(posedge clk);
            #1;
            n++;
        end
        if (limit == 0) begin
            if (retire) model_cnt = model_cnt + 32'd1;
            check_output($sformatf("%s instret", tag), cur_instret(), model_cnt & cnt_mask());
        end
    endtask

    task automatic random_instr(input string tag);
        logic [5:0] o = op_tab[$urandom_range(0, 8)];
        logic [5:0] f = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 4)]
                                                    : 6'($urandom);
        apply_stimulus(tag, o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                       $urandom_range(0, 3), 0);
    endtask

    // Hold the selected DUT in reset, confirm all outputs are zero, then release.
    task automatic reset_dut(input string tag);
        if (sel == 1) rst_b = 1'b1; else rst_a = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check_output($sformatf("%s outputs", tag), 32'(cur_obs()), 32'd0);
        check_output($sformatf("%s instret", tag), cur_instret(), 32'd0);
        @(posedge clk);
        #1;
        if (sel == 1) rst_b = 1'b0; else rst_a = 1'b0;
        model_cnt = 32'd0;
    endtask

    initial begin
        ctl_t fw;
        @(posedge clk);
        #1;
        sel = 0; cur_wait = 1'b1; cur_bne = 1'b1; cur_w = 32;
        reset_dut("reset_a");

        apply_stimulus("lw_fast", 6'b100011, 6'b000000, 1'b0, 0, 0, 0);
        apply_stimulus("sw_stall", 6'b101011, 6'b100000, 1'b0, 0, 2, 0);
        apply_stimulus("beq_taken", 6'b000100, 6'b000000, 1'b1, 0, 0, 0);
        apply_stimulus("beq_not", 6'b000100, 6'b000000, 1'b0, 1, 0, 0);
        apply_stimulus("bne_zero", 6'b000101, 6'b000000, 1'b1, 0, 0, 0);
        apply_stimulus("bne_taken", 6'b000101, 6'b000000, 1'b0, 0, 0, 0);
        apply_stimulus("r_slt", 6'b000000, 6'b101010, 1'b0, 0, 0, 0);
        apply_stimulus("r_bad", 6'b000000, 6'b000111, 1'b0, 0, 0, 0);
        apply_stimulus("addi", 6'b001000, 6'b111111, 1'b0, 2, 0, 0);
        apply_stimulus("bad_op", 6'b111111, 6'b100000, 1'b0, 0, 0, 0);
        for (int i = 0; i < 120; i++) random_instr("rand_a");

        // Reset in the second MEMRD stall cycle of a lw.
        apply_stimulus("lw_rst", 6'b100011, 6'b000000, 1'b0, 0, 3, 4);
        rst_a = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check_output("rst_mid outputs", 32'(obs_a), 32'd0);
        check_output("rst_mid regwrite", 32'(bus_a.regwrite), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        model_cnt = 32'd0;
        @(negedge clk);
        fw = base(); fw.memread = 1'b1; fw.alusrcb = 2'b01;
        check_output("rst_mid fetch", 32'(obs_a), 32'(fw));
        check_output("rst_mid instret", bus_a.instret, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) random_instr("rand_a2");

        rst_a = 1'b1;
        sel = 1; cur_wait = 1'b0; cur_bne = 1'b0; cur_w = 4;
        reset_dut("reset_b");
        apply_stimulus("bne_off", 6'b000101, 6'b000000, 1'b0, 0, 0, 0);
        apply_stimulus("lw_nowait", 6'b100011, 6'b000000, 1'b0, 0, 0, 0);
        for (int i = 0; i < 17; i++) apply_stimulus($sformatf("j_wrap%0d", i), 6'b000010,
                                                    6'($urandom), 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) random_instr("rand_b");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
